m2_sram_arbiter: RTL

Shares the single external SRAM port between the two Milestone 2 SRAM engines. The fetch engine reads pre-IDCT S' coefficients from address 76800 upward. The write engine writes packed YUV pixel pairs to the Y/U/V regions. The block grants whole bursts with round-robin fairness and withholds write grants while reads are still returning. It registers every SRAM command and tags returned read data with a valid strobe for the fetch engine.

---
 rtl/m2_sram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/m2_sram_arbiter.sv
// ============================================================================
// m2_sram_arbiter
//
// Shares the single external SRAM port between the two Milestone 2 engines:
// the fetch engine (reads pre-IDCT S' coefficients) and the write engine
// (writes packed YUV pixel pairs). Whole bursts are granted with round-robin
// fairness. A write grant is withheld while any read beat still has a data
// return ahead of it. Every SRAM command is registered, and returned read data
// is tagged with a valid strobe for the fetch engine.
//
// Ports
//   Clock, Resetn       system clock / asynchronous active-low reset
//   F_req, F_address,   fetch engine beat request, address, last-beat flag
//   F_last
//   F_gnt               fetch engine holds the port
//   F_rdata,            read data (combinational from SRAM) and its valid tag
//   F_rdata_valid
//   W_req, W_address,   write engine beat request, address, data, last flag
//   W_write_data,
//   W_last
//   W_gnt               write engine holds the port
//   SRAM_address,       registered SRAM command pins
//   SRAM_write_data,
//   SRAM_we_n
//   SRAM_read_data      SRAM read data, READ_LATENCY cycles after the address
//   burst_error         sticky: a burst reached MAX_BURST without its last beat
// ============================================================================
module m2_sram_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 64
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        F_req,
    input  logic [17:0] F_address,
    input  logic        F_last,
    output logic        F_gnt,
    output logic [15:0] F_rdata,
    output logic        F_rdata_valid,
    input  logic        W_req,
    input  logic [17:0] W_address,
    input  logic [15:0] W_write_data,
    input  logic        W_last,
    output logic        W_gnt,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        burst_error
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_W = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    lastServedW_q;
    logic [CNT_W-1:0]        beatCnt_q;
    logic [READ_LATENCY:0]   tagPipe_q;
    logic [17:0]             sramAddress_q;
    logic [15:0]             sramWriteData_q;
    logic                    sramWeN_q;
    logic                    burstError_q;

    logic                    readsPending;
    logic                    wEligible;
    logic                    fEligible;
    logic                    fBeat;
    logic                    wBeat;
    logic                    beatLast;
    logic [CNT_W-1:0]        beatCntInc;
    logic                    hitMax;
    logic                    burstEnd;

    // A tag in the final pipe stage is being returned this cycle, so only the
    // earlier stages represent reads whose data is still to come.
    assign readsPending = |tagPipe_q[READ_LATENCY-1:0];
    assign wEligible    = W_req & ~readsPending;
    assign fEligible    = F_req;

    assign fBeat      = (state_q == GNT_F) & F_req;
    assign wBeat      = (state_q == GNT_W) & W_req;
    assign beatLast   = fBeat ? F_last : W_last;
    assign beatCntInc = beatCnt_q + CNT_W'(1);
    assign hitMax     = (beatCntInc == CNT_W'(MAX_BURST));
    assign burstEnd   = (fBeat | wBeat) & (beatLast | hitMax);

    // Grant FSM, beat counter, read-tag pipe and registered SRAM command.
    // A granted requester keeps the port while idle (burst lock); the port
    // always drops to IDLE for one cycle between bursts.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= IDLE;
            lastServedW_q   <= 1'b0;
            beatCnt_q       <= '0;
            tagPipe_q       <= '0;
            sramAddress_q   <= '0;
            sramWriteData_q <= '0;
            sramWeN_q       <= 1'b1;
            burstError_q    <= 1'b0;
        end else begin
            tagPipe_q <= {tagPipe_q[READ_LATENCY-1:0], fBeat};
            sramWeN_q <= ~wBeat;

            if (fBeat) begin
                sramAddress_q <= F_address;
            end
            if (wBeat) begin
                sramAddress_q   <= W_address;
                sramWriteData_q <= W_write_data;
            end

            if (fBeat | wBeat) begin
                beatCnt_q <= burstEnd ? '0 : beatCntInc;
            end

            if (burstEnd) begin
                state_q       <= IDLE;
                lastServedW_q <= wBeat;
                if (!beatLast) begin
                    burstError_q <= 1'b1;
                end
            end else if (state_q == IDLE) begin
                // On a tie the requester not served last wins.
                if (fEligible && wEligible) begin
                    state_q <= lastServedW_q ? GNT_F : GNT_W;
                end else if (wEligible) begin
                    state_q <= GNT_W;
                end else if (fEligible) begin
                    state_q <= GNT_F;
                end
            end
        end
    end

    assign F_gnt           = (state_q == GNT_F);
    assign W_gnt           = (state_q == GNT_W);
    assign F_rdata         = SRAM_read_data;
    assign F_rdata_valid   = tagPipe_q[READ_LATENCY];
    assign SRAM_address    = sramAddress_q;
    assign SRAM_write_data = sramWriteData_q;
    assign SRAM_we_n       = sramWeN_q;
    assign burst_error     = burstError_q;

endmodule
